module_pkt_gen: RTL and testbench

MODULE_PKT_GEN -- requirements
Module: module_pkt_gen

---
 rtl/module_pkt_gen.sv | 185 ++++++++++++++++++
 tb/tb_module_pkt_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/module_pkt_gen.sv
// Multi-channel packet generator: one IDLE/SEND/GAP FSM per channel emits
// command/single packets on a valid/ready link, with run control and a handshake counter.
module module_pkt_gen #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16,
  parameter int GAP_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 stop,
  input  logic [1:0]           mode,
  input  logic [CNT_W-1:0]     burst_len,
  input  logic [GAP_W-1:0]     gap,
  input  logic [NCH-1:0]       ch_en,
  input  logic [31:0]          cmd_payload,
  input  logic [NCH-1:0]       ready,
  output logic [NCH-1:0]       valid,
  output logic [NCH*128-1:0]   data,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     sent_count
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_SEND = 2'd1, S_GAP = 2'd2} state_e;

  function automatic logic [127:0] build_pkt(input logic [3:0] ch, input logic single,
                                             input logic [31:0] payload);
    build_pkt = {5'b11111, single, ch, 2'b00, ~single, 83'd0, payload};
  endfunction

  state_e           state_q [NCH];
  state_e           state_d [NCH];
  logic [31:0]      seq_q   [NCH];
  logic [31:0]      seq_d   [NCH];
  logic [GAP_W-1:0] gcnt_q  [NCH];
  logic [GAP_W-1:0] gcnt_d  [NCH];
  logic [NCH-1:0]   stop_pend_q, stop_pend_d;

  logic [1:0]       mode_q;
  logic [CNT_W-1:0] burst_q;
  logic [GAP_W-1:0] gap_q;
  logic [NCH-1:0]   chen_q;
  logic [31:0]      cmd_q;

  logic             busy_q, busy_d, busy_dly_q, done_q, done_d;
  logic [CNT_W-1:0] sent_q, sent_d;

  logic             accept_s;
  logic [NCH-1:0]   hs_s;
  logic [31:0]      burst32_s;
  logic [4:0]       pop_s;
  logic [CNT_W:0]   sum_s;

  assign accept_s  = start & ~busy_q;
  assign hs_s      = valid & ready;
  assign burst32_s = 32'(burst_q);

  // State, sequence, gap counters and run bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= S_IDLE;
        seq_q[k]   <= 32'd0;
        gcnt_q[k]  <= '0;
      end
      stop_pend_q <= '0;
      mode_q      <= 2'd0;
      burst_q     <= '0;
      gap_q       <= '0;
      chen_q      <= '0;
      cmd_q       <= 32'd0;
      busy_q      <= 1'b0;
      busy_dly_q  <= 1'b0;
      done_q      <= 1'b0;
      sent_q      <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        state_q[k] <= state_d[k];
        seq_q[k]   <= seq_d[k];
        gcnt_q[k]  <= gcnt_d[k];
      end
      stop_pend_q <= stop_pend_d;
      if (accept_s) begin
        mode_q  <= (mode == 2'd3) ? 2'd0 : mode;
        burst_q <= burst_len;
        gap_q   <= gap;
        chen_q  <= ch_en;
        cmd_q   <= cmd_payload;
      end
      busy_q     <= busy_d;
      busy_dly_q <= busy_q;
      done_q     <= done_d;
      sent_q     <= sent_d;
    end
  end

  // Next-state logic for every channel FSM plus busy/done/counter.
  always_comb begin
    busy_d = 1'b0;
    pop_s  = 5'd0;
    for (int k = 0; k < NCH; k++) begin
      state_d[k]     = state_q[k];
      seq_d[k]       = seq_q[k];
      gcnt_d[k]      = gcnt_q[k];
      stop_pend_d[k] = stop_pend_q[k];
      case (state_q[k])
        S_IDLE: begin
          if (accept_s && ch_en[k]) begin
            state_d[k]     = S_SEND;
            seq_d[k]       = 32'd0;
            stop_pend_d[k] = 1'b0;
          end else begin
            state_d[k] = S_IDLE;
          end
        end
        S_SEND: begin
          if (hs_s[k]) begin
            seq_d[k] = seq_q[k] + 32'd1;
            // Stop wins over burst continuation; the handshake itself still counts.
            if (stop || stop_pend_q[k]) begin
              state_d[k]     = S_IDLE;
              stop_pend_d[k] = 1'b0;
            end else if ((burst_q != '0) && (seq_q[k] + 32'd1 == burst32_s)) begin
              state_d[k] = S_IDLE;
            end else if (gap_q != '0) begin
              state_d[k] = S_GAP;
              gcnt_d[k]  = gap_q - GAP_W'(1);
            end else begin
              state_d[k] = S_SEND;
            end
          end else if (stop) begin
            stop_pend_d[k] = 1'b1;
          end else begin
            stop_pend_d[k] = stop_pend_q[k];
          end
        end
        S_GAP: begin
          if (stop) begin
            state_d[k] = S_IDLE;
          end else if (gcnt_q[k] == '0) begin
            state_d[k] = S_SEND;
          end else begin
            gcnt_d[k] = gcnt_q[k] - GAP_W'(1);
          end
        end
        default: state_d[k] = S_IDLE;
      endcase
      busy_d = busy_d | (state_d[k] != S_IDLE);
      pop_s  = pop_s + 5'(hs_s[k]);
    end

    done_d = (accept_s & ~(|ch_en)) | (busy_dly_q & ~busy_q);

    sum_s = {1'b0, sent_q} + (CNT_W+1)'(pop_s);
    if (accept_s) begin
      sent_d = '0;
    end else if (sum_s[CNT_W]) begin
      sent_d = '1;
    end else begin
      sent_d = sum_s[CNT_W-1:0];
    end
  end

  // Output decode: valid and packet contents from registered channel state.
  always_comb begin
    valid = '0;
    data  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (state_q[k] == S_SEND && chen_q[k]) begin
        valid[k] = 1'b1;
        data[128*k +: 128] = build_pkt(4'(k),
            (mode_q == 2'd1) | ((mode_q == 2'd2) & seq_q[k][0]),
            ((mode_q == 2'd1) | ((mode_q == 2'd2) & seq_q[k][0])) ? seq_q[k] : cmd_q);
      end else begin
        valid[k] = 1'b0;
      end
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign sent_count = sent_q;

endmodule

// File: tb/tb_module_pkt_gen.sv
// Self-checking bench for module_pkt_gen: table-driven runs, hand-written
// corner sequences and randomized runs scored against a packet-level model.
module tb_module_pkt_gen;

  localparam int NCH = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stop;
  logic [1:0]         mode;
  logic [15:0]        burst_len, gap;
  logic [NCH-1:0]     ch_en, ready, valid;
  logic [31:0]        cmd_payload;
  logic [NCH*128-1:0] data;
  logic               busy, done;
  logic [15:0]        sent_count;

  int vec_cnt = 0;
  int err_cnt = 0;

  module_pkt_gen #(.NCH(NCH), .CNT_W(16), .GAP_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode),
    .burst_len(burst_len), .gap(gap), .ch_en(ch_en), .cmd_payload(cmd_payload),
    .ready(ready), .valid(valid), .data(data), .busy(busy), .done(done),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  md;
    logic [15:0] bl;
    logic [15:0] gp;
    logic [3:0]  ce;
    logic [31:0] cm;
    bit          rr;
    logic [15:0] exp_sent;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference packet built directly from the field layout.
  function automatic logic [127:0] exp_pkt(input int k, input logic [1:0] md,
                                           input int unsigned sq, input logic [31:0] cmd);
    logic single;
    logic [127:0] p;
    logic [3:0] kk;
    kk = 4'(k);
    single = (md == 2'd1) || (md == 2'd2 && (sq % 2) == 1);
    p = '0;
    p[127:123] = 5'b11111;
    p[122] = single;
    p[121:118] = kk;
    p[115] = !single;
    p[31:0] = single ? sq : cmd;
    return p;
  endfunction

  task automatic run_cfg(input string nm, input logic [1:0] md, input logic [15:0] bl,
                         input logic [15:0] gp, input logic [3:0] ce, input logic [31:0] cm,
                         input bit rr, input logic [15:0] exp_sent);
    int eseq[NCH];
    int lowrun[NCH];
    bit prevv[NCH];
    bit fin;
    logic [1:0] emd;
    emd = (md == 2'd3) ? 2'd0 : md;
    for (int i = 0; i < 200 && busy; i++) tick();
    ready = 4'hF;
    start = 1'b1; mode = md; burst_len = bl; gap = gp; ch_en = ce; cmd_payload = cm;
    tick();
    start = 1'b0;
    mode = 2'($urandom); burst_len = 16'($urandom); gap = 16'($urandom);
    ch_en = 4'($urandom); cmd_payload = $urandom;
    chk({nm, " latency"}, valid, ce);
    for (int k = 0; k < NCH; k++) begin
      eseq[k] = 0; lowrun[k] = 0; prevv[k] = 1'b0;
    end
    fin = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (!busy) begin
        fin = 1'b1;
        break;
      end
      chk({nm, " enable mask"}, valid & ~ce, 4'h0);
      ready = rr ? 4'($urandom) : 4'hF;
      for (int k = 0; k < NCH; k++) begin
        if (valid[k]) begin
          if (!prevv[k] && eseq[k] > 0) chk({nm, " gap length"}, 128'(lowrun[k]), 128'(gp));
          lowrun[k] = 0;
          chk({nm, " data"}, data[128*k +: 128], exp_pkt(k, emd, eseq[k], cm));
          if (ready[k]) eseq[k]++;
        end else begin
          lowrun[k]++;
        end
        prevv[k] = valid[k];
      end
      tick();
    end
    chk({nm, " finished in budget"}, 128'(fin), 128'(1));
    for (int k = 0; k < NCH; k++)
      if (ce[k]) chk({nm, " packets per channel"}, 128'(eseq[k]), 128'(bl));
    chk({nm, " sent_count"}, sent_count, exp_sent);
    ready = 4'hF;
    tick();
    chk({nm, " done pulse"}, done, 1'b1);
    tick();
    chk({nm, " done low"}, done, 1'b0);
  endtask

  vec_t tbl[5];

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; mode = 2'd0; burst_len = 16'd0; gap = 16'd0;
    ch_en = 4'h0; cmd_payload = 32'd0; ready = 4'hF;

    tbl[0] = '{md: 2'd1, bl: 16'd3, gp: 16'd0, ce: 4'hF, cm: 32'h11223344, rr: 1'b0, exp_sent: 16'd12};
    tbl[1] = '{md: 2'd2, bl: 16'd4, gp: 16'd5, ce: 4'h1, cm: 32'hDEADBEEF, rr: 1'b1, exp_sent: 16'd4};
    tbl[2] = '{md: 2'd0, bl: 16'd2, gp: 16'd1, ce: 4'hA, cm: 32'h12345678, rr: 1'b1, exp_sent: 16'd4};
    tbl[3] = '{md: 2'd3, bl: 16'd3, gp: 16'd2, ce: 4'h4, cm: 32'hA5A5A5A5, rr: 1'b0, exp_sent: 16'd3};
    tbl[4] = '{md: 2'd2, bl: 16'd5, gp: 16'd0, ce: 4'h6, cm: 32'h0BADF00D, rr: 1'b1, exp_sent: 16'd10};

    repeat (3) tick();
    chk("reset valid", valid, 4'h0);
    chk("reset data", 128'(|data), 128'(0));
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset sent_count", sent_count, 16'd0);
    rst_n = 1'b1;
    tick();

    // Single command packet on channel 0 with an exact expected image.
    mode = 2'd0; burst_len = 16'd1; gap = 16'd0; ch_en = 4'h1; cmd_payload = 32'h0400FF64;
    ready = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    chk("cmd pkt valid", valid, 4'h1);
    chk("cmd pkt data", data[127:0], 128'hF8080000_00000000_00000000_0400FF64);
    tick();
    chk("cmd pkt valid drop", valid, 4'h0);
    chk("cmd pkt busy fall", busy, 1'b0);
    tick();
    chk("cmd pkt done", done, 1'b1);
    chk("cmd pkt sent", sent_count, 16'd1);
    tick();
    chk("cmd pkt done low", done, 1'b0);

    // Start with no channel enabled.
    ch_en = 4'h0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty busy", busy, 1'b0);
    chk("empty done", done, 1'b1);
    tick();
    chk("empty done low", done, 1'b0);

    for (int i = 0; i < 5; i++)
      run_cfg($sformatf("tbl%0d", i), tbl[i].md, tbl[i].bl, tbl[i].gp, tbl[i].ce,
              tbl[i].cm, tbl[i].rr, tbl[i].exp_sent);

    // Stop while SEND is stalled: valid holds until the handshake.
    mode = 2'd1; burst_len = 16'd0; gap = 16'd0; ch_en = 4'h1; ready = 4'h0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop send held", valid, 4'h1);
    chk("stop send payload", data[31:0], 32'd0);
    tick();
    chk("stop send still busy", busy, 1'b1);
    ready = 4'hF;
    tick();
    chk("stop send released", valid, 4'h0);
    chk("stop send busy", busy, 1'b0);
    tick();
    chk("stop send done", done, 1'b1);
    chk("stop send sent", sent_count, 16'd1);
    tick();

    // Stop while in GAP: immediate return to IDLE.
    mode = 2'd0; gap = 16'd10; ch_en = 4'h3; cmd_payload = 32'h11111111; start = 1'b1;
    tick();
    start = 1'b0;
    chk("stop gap first valid", valid, 4'h3);
    tick();
    chk("stop gap in gap", valid, 4'h0);
    chk("stop gap busy", busy, 1'b1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("stop gap idle", busy, 1'b0);
    tick();
    chk("stop gap done", done, 1'b1);
    chk("stop gap sent", sent_count, 16'd2);
    tick();

    // Start while busy is ignored; then asynchronous reset mid-run.
    mode = 2'd1; burst_len = 16'd4; gap = 16'd0; ch_en = 4'h1; ready = 4'hF; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    start = 1'b1; mode = 2'd0; cmd_payload = 32'hCAFEF00D;
    tick();
    start = 1'b0;
    chk("busy start ignored sent", sent_count, 16'd3);
    chk("busy start ignored payload", data[31:0], 32'd3);
    rst_n = 1'b0;
    #1;
    chk("async reset valid", valid, 4'h0);
    chk("async reset data", 128'(|data), 128'(0));
    chk("async reset busy", busy, 1'b0);
    chk("async reset sent", sent_count, 16'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    run_cfg("after reset", 2'd2, 16'd2, 16'd1, 4'h9, 32'h55AA55AA, 1'b1, 16'd4);

    for (int i = 0; i < 15; i++) begin
      logic [1:0] md;
      logic [15:0] bl, gp;
      logic [3:0] ce;
      md = 2'($urandom_range(0, 3));
      bl = 16'($urandom_range(1, 6));
      gp = 16'($urandom_range(0, 6));
      ce = 4'($urandom_range(1, 15));
      run_cfg($sformatf("rnd%0d", i), md, bl, gp, ce, $urandom, 1'b1,
              16'($countones(ce)) * bl);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
